// File: rtl/median_filter_pkg.sv
// Shared types and constants for the 3x3 median window controller.
package median_filter_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  function automatic logic is_border(input int unsigned row, input int unsigned col,
                                     input int unsigned last_row, input int unsigned last_col);
    return (row == 0) || (col == 0) || (row == last_row) || (col == last_col);
  endfunction

endpackage

// File: rtl/median_window_controller_if.sv
// Pixel-in / pixel-out valid-ready streams of the median window controller.
interface median_window_controller_if;
  import median_filter_pkg::*;

  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  // Environment side: pixel source and image sink.
  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid, out_last
  );

  // Controller side.
  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid, out_last
  );

endinterface

// File: rtl/Median_Finder_9inputs_8bits.sv
// Combinational median of nine 8-bit pixels by rank counting.
module Median_Finder_9inputs_8bits (
  input  logic [7:0] pix0_i,
  input  logic [7:0] pix1_i,
  input  logic [7:0] pix2_i,
  input  logic [7:0] pix3_i,
  input  logic [7:0] pix4_i,
  input  logic [7:0] pix5_i,
  input  logic [7:0] pix6_i,
  input  logic [7:0] pix7_i,
  input  logic [7:0] pix8_i,
  output logic [7:0] median_o
);

  logic [7:0] v    [9];
  logic [3:0] rank [9];

  assign v[0] = pix0_i;
  assign v[1] = pix1_i;
  assign v[2] = pix2_i;
  assign v[3] = pix3_i;
  assign v[4] = pix4_i;
  assign v[5] = pix5_i;
  assign v[6] = pix6_i;
  assign v[7] = pix7_i;
  assign v[8] = pix8_i;

  // Ties broken by input index so the ranks form a permutation of 0..8.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      rank[i] = '0;
      for (int j = 0; j < 9; j++) begin
        if (j != i && ((v[j] < v[i]) || (v[j] == v[i] && j < i))) begin
          rank[i] = rank[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    median_o = '0;
    for (int i = 0; i < 9; i++) begin
      if (rank[i] == 4'd4) begin
        median_o = v[i];
      end
    end
  end

endmodule

// File: rtl/median_line_buffer.sv
// One stored image row: a Depth-entry shift register advanced once per window step.
module median_line_buffer #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  logic [Width-1:0] mem_q [Depth];

  // Pixel data only; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[Depth-1];

endmodule

// File: rtl/median_window_controller.sv
// Streaming 3x3 median filter sequencer: two line buffers, a sliding window and a one-entry
// output register; border pixels and bypassed frames pass through unchanged.
module median_window_controller
  import median_filter_pkg::*;
#(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_bypass,
  median_window_controller_if.slave        stream,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0]    in_row_q, in_row_d, out_row_q, out_row_d;
  logic             bypass_q, bypass_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;

  logic             in_ready, accept, drain, flush_adv, adv, emit;
  logic             fill_done, in_last, border;
  logic [PIX_W-1:0] new_pix, lb0_out, lb1_out, med, center;
  logic [PIX_W-1:0] win_q [2][3];

  assign in_ready  = (state_q != StFlush) && (!out_valid_q || stream.out_ready);
  assign accept    = in_ready && stream.in_valid;
  assign drain     = out_valid_q && stream.out_ready;
  // FLUSH keeps stepping the window with dummy pixels until the last output is loaded.
  assign flush_adv = (state_q == StFlush) && (!out_valid_q || stream.out_ready) &&
                     !(out_valid_q && out_last_q);
  assign adv       = accept || flush_adv;
  assign fill_done = (in_row_q == RW'(1)) && (in_col_q == CW'(1));
  assign in_last   = (in_row_q == RowLast) && (in_col_q == ColLast);
  assign emit      = flush_adv ||
                     (accept && ((state_q == StRun) || (state_q == StFill && fill_done)));
  assign new_pix   = (state_q == StFlush) ? '0 : stream.in_pixel;

  median_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb0 (
    .clk_i  (clk),
    .en_i   (adv),
    .din_i  (new_pix),
    .dout_o (lb0_out)
  );

  median_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb1 (
    .clk_i  (clk),
    .en_i   (adv),
    .din_i  (lb0_out),
    .dout_o (lb1_out)
  );

  // Two registered columns plus the incoming column form the 3x3 window seen at load time.
  always_ff @(posedge clk) begin
    if (adv) begin
      win_q[0]    <= win_q[1];
      win_q[1][0] <= lb1_out;
      win_q[1][1] <= lb0_out;
      win_q[1][2] <= new_pix;
    end
  end

  Median_Finder_9inputs_8bits u_median (
    .pix0_i   (win_q[0][0]),
    .pix1_i   (win_q[1][0]),
    .pix2_i   (lb1_out),
    .pix3_i   (win_q[0][1]),
    .pix4_i   (win_q[1][1]),
    .pix5_i   (lb0_out),
    .pix6_i   (win_q[0][2]),
    .pix7_i   (win_q[1][2]),
    .pix8_i   (new_pix),
    .median_o (med)
  );

  assign center = win_q[1][1];
  assign border = is_border(32'(out_row_q), 32'(out_col_q), IMG_H - 1, IMG_W - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StFill;
      StFill:  if (accept && fill_done) state_d = StRun;
      StRun:   if (accept && in_last) state_d = StFlush;
      StFlush: if (drain && out_last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    bypass_d     = bypass_q;
    out_pixel_d  = out_pixel_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = drain && out_last_q;

    if (accept) begin
      if (state_q == StIdle) bypass_d = cfg_bypass;
      if (in_col_q == ColLast) begin
        in_col_d = '0;
        in_row_d = (in_row_q == RowLast) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    if (drain) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_pixel_d = (bypass_q || border) ? center : med;
      out_last_d  = (out_row_q == RowLast) && (out_col_q == ColLast);
      if (out_col_q == ColLast) begin
        out_col_d = '0;
        out_row_d = (out_row_q == RowLast) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
  end

  // The bypass flag is sampled on the first accept, so it is valid well before any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      bypass_q     <= 1'b0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      bypass_q     <= bypass_d;
      out_pixel_q  <= out_pixel_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign stream.in_ready  = in_ready;
  assign stream.out_pixel = out_pixel_q;
  assign stream.out_valid = out_valid_q;
  assign stream.out_last  = out_last_q;
  assign busy             = (state_q != StIdle);
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_median_window_controller.sv
// Scoreboard bench for median_window_controller on a 4x4 frame.
module tb_median_window_controller;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic cfg_bypass;
  logic busy;
  logic frame_done;

  median_window_controller_if bus ();

  median_window_controller #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_bypass (cfg_bypass),
    .stream     (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  exp_t       exp_q [$];
  logic [7:0] frm [N];
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  bit         stall_mode = 1'b0;
  bit         gap_mode = 1'b0;
  bit         chk_done = 1'b0;
  bit         done_seen = 1'b0;
  int         rdy_phase = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] med9(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (s[j] < s[j-1]) begin
          t = s[j]; s[j] = s[j-1]; s[j-1] = t;
        end
      end
    end
    return s[4];
  endfunction

  task automatic push_expected(input bit bp);
    logic [7:0] nb [9];
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (bp || r == 0 || c == 0 || r == H - 1 || c == W - 1) begin
          e.pix = frm[r*W+c];
        end else begin
          for (int k = 0; k < 9; k++) nb[k] = frm[(r + k/3 - 1)*W + c + k%3 - 1];
          e.pix = med9(nb);
        end
        e.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the pixel is accepted.
  task automatic drive_pixel(input logic [7:0] p);
    int n = 0;
    bus.in_pixel = p;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit bp);
    done_seen  = 1'b0;
    cfg_bypass = bp;
    push_expected(bp);
    for (int i = 0; i < N; i++) begin
      drive_pixel(frm[i]);
      // Flipping the input after the first pixel shows the mode is latched per frame.
      if (i == 0) cfg_bypass = !bp;
      if (gap_mode) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n = 0;
    while ((exp_q.size() != 0 || !done_seen) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) check("frame_timeout", 32'(exp_q.size()), 0);
    done_seen = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        bus.out_ready = (rdy_phase == 0) || (rdy_phase == 3);
        rdy_phase     = (rdy_phase + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (chk_done) begin
        check("frame_done", 32'(frame_done), 1);
        chk_done  = 1'b0;
        done_seen = 1'b1;
      end else if (frame_done) begin
        check("frame_done_spurious", 32'(frame_done), 0);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 32'(bus.out_valid), 0);
        end else if (bus.out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pixel", 32'(bus.out_pixel), 32'(e.pix));
          check("out_last", 32'(bus.out_last), 32'(e.last));
          chk_done = e.last;
        end else begin
          check("stall_pixel", 32'(bus.out_pixel), 32'(exp_q[0].pix));
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    cfg_bypass   = 1'b0;
    bus.in_pixel = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_pixel", 32'(bus.out_pixel), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Constant frame.
    for (int i = 0; i < N; i++) frm[i] = 8'd1;
    send_frame(1'b0);
    wait_frame();

    // Ramp 1..16.
    for (int i = 0; i < N; i++) frm[i] = 8'(i + 1);
    send_frame(1'b0);
    wait_frame();

    // Impulse noise inside the frame.
    for (int i = 0; i < N; i++) frm[i] = 8'd10;
    frm[1*W+1] = 8'd255;
    frm[2*W+2] = 8'd255;
    send_frame(1'b0);
    wait_frame();

    // Ramp under sink back-pressure and source gaps.
    for (int i = 0; i < N; i++) frm[i] = 8'(i + 1);
    stall_mode = 1'b1;
    gap_mode   = 1'b1;
    send_frame(1'b0);
    wait_frame();
    stall_mode = 1'b0;
    gap_mode   = 1'b0;

    // Random frame exercising general medians.
    for (int i = 0; i < N; i++) frm[i] = 8'($urandom_range(0, 255));
    send_frame(1'b0);
    wait_frame();

    // Abort a frame after 7 inputs with an asynchronous reset.
    mon_en = 1'b0;
    for (int i = 0; i < 7; i++) drive_pixel(8'(100 + i));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    exp_q.delete();
    chk_done = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < N; i++) frm[i] = 8'(i + 1);
    send_frame(1'b0);
    wait_frame();

    // Bypass frame followed by a filtered frame.
    send_frame(1'b1);
    wait_frame();
    send_frame(1'b0);
    wait_frame();

    check("idle_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
